// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 frame receiver with show-ahead scancode FIFO
module ps2_scancode_rx #(
    parameter int DEPTH_LOG2 = 3,
    parameter int TIMEOUT    = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    input  logic       ovf_clr,
    output logic [7:0] data,
    output logic       valid,
    output logic       overflow,
    output logic       frame_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int IW    = $clog2(TIMEOUT + 1);
    localparam int PW    = DEPTH_LOG2 + 1;

    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);
    localparam logic [IW-1:0] IDLE_ONE = IW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic s1, s2, s3;
    logic d1, d2;
    logic fall;

    logic [3:0]    cnt;
    logic [9:0]    shift_buf;
    logic [IW-1:0] idle;

    logic stop_seen;
    logic frame_ok;
    logic good_frame;

    logic [PW-1:0] wp, rp;
    logic [7:0]    mem [DEPTH];
    logic          empty, full, pop, push, ovf_set;

    // Bring the asynchronous PS/2 pins into the clk domain; clock gets a third
    // stage so the falling-edge detector compares two settled samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
            d1 <= 1'b1;
            d2 <= 1'b1;
        end else begin
            s1 <= ps2_clk;
            s2 <= s1;
            s3 <= s2;
            d1 <= ps2_data;
            d2 <= d1;
        end
    end

    assign fall = s3 & ~s2;

    // Frame checks: start low, stop high, odd parity over data and parity bit.
    always_comb begin
        stop_seen  = fall && (cnt == 4'd10);
        frame_ok   = ~shift_buf[0] & d2 & (^shift_buf[9:1]);
        good_frame = stop_seen & frame_ok;
        frame_err  = stop_seen & ~frame_ok;
    end

    // Bit collector plus idle watchdog that drops a stalled partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 4'd0;
            shift_buf <= 10'd0;
            idle      <= '0;
        end else if (fall) begin
            idle <= '0;
            if (cnt == 4'd10) begin
                cnt <= 4'd0;
            end else begin
                shift_buf[cnt] <= d2;
                cnt            <= cnt + 4'd1;
            end
        end else if (cnt == 4'd0) begin
            idle <= '0;
        end else if (idle == IDLE_MAX) begin
            cnt  <= 4'd0;
            idle <= '0;
        end else begin
            idle <= idle + IDLE_ONE;
        end
    end

    // FIFO status; a pop in the same cycle frees the slot a full FIFO needs.
    always_comb begin
        empty   = (wp == rp);
        full    = (wp[DEPTH_LOG2] != rp[DEPTH_LOG2]) &&
                  (wp[DEPTH_LOG2-1:0] == rp[DEPTH_LOG2-1:0]);
        valid   = ~empty;
        pop     = rd_en & ~empty;
        push    = good_frame & (~full | pop);
        ovf_set = good_frame & full & ~pop;
        data    = mem[rp[DEPTH_LOG2-1:0]];
    end

    // Read and write pointers advance independently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + PTR_ONE;
            if (pop)  rp <= rp + PTR_ONE;
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wp[DEPTH_LOG2-1:0]] <= shift_buf[8:1];
    end

    // Sticky overflow; a new drop outranks a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb/tb_ps2_scancode_rx.sv - randomized self-checking bench for ps2_scancode_rx
module tb_ps2_scancode_rx;

    localparam int HALF    = 20;
    localparam int TIMEOUT = 2000;
    localparam int DEPTH   = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rd_en;
    logic       ovf_clr;
    logic [7:0] data;
    logic       valid;
    logic       overflow;
    logic       frame_err;

    int         n_checks = 0;
    int         n_fails  = 0;
    logic [7:0] model_q[$];
    bit         model_ovf = 1'b0;
    int         bad_sent  = 0;
    int         err_hi    = 0;

    ps2_scancode_rx #(.DEPTH_LOG2(3), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rd_en    (rd_en),
        .ovf_clr  (ovf_clr),
        .data     (data),
        .valid    (valid),
        .overflow (overflow),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Count every cycle frame_err is seen high; each bad frame must add exactly one.
    always @(negedge clk) begin
        if (frame_err === 1'b1) err_hi++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // bad_kind: 0 good, 1 start high, 2 parity flipped, 3 stop low.
    function automatic logic [10:0] make_frame(input logic [7:0] b, input int bad_kind);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = ~^b;
        f[10]  = 1'b1;
        case (bad_kind)
            1:       f[0]  = 1'b1;
            2:       f[9]  = ~f[9];
            3:       f[10] = 1'b0;
            default: ;
        endcase
        return f;
    endfunction

    task automatic ps2_bit(input logic v);
        @(negedge clk);
        ps2_data = v;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int bad_kind, input bit pop_at_stop);
        logic [10:0] f;
        bit          good;
        int          sz_before;
        f    = make_frame(b, bad_kind);
        good = (bad_kind == 0);
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        @(negedge clk);
        ps2_data = f[10];
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;

        sz_before = model_q.size();
        if (pop_at_stop && sz_before > 0) void'(model_q.pop_front());
        if (good) begin
            if (model_q.size() < DEPTH) model_q.push_back(b);
            else model_ovf = 1'b1;
        end else begin
            bad_sent++;
        end

        @(negedge clk);
        check("err_early", frame_err, 0);
        @(negedge clk);
        check("err_stop", frame_err, {31'd0, !good});
        check("valid_pre", valid, {31'd0, sz_before > 0});
        rd_en = pop_at_stop;
        @(negedge clk);
        rd_en = 1'b0;
        check("err_after", frame_err, 0);
        check("valid_post", valid, {31'd0, model_q.size() > 0});
        if (model_q.size() > 0) check("data_post", data, model_q[0]);
        check("ovf_post", overflow, {31'd0, model_ovf});
        repeat (HALF - 3) @(negedge clk);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
    endtask

    task automatic pop_burst(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("pop_valid", valid, {31'd0, model_q.size() > 0});
            if (model_q.size() > 0) begin
                check("pop_data", data, model_q[0]);
                void'(model_q.pop_front());
            end
            rd_en = 1'b1;
        end
        @(negedge clk);
        rd_en = 1'b0;
        check("pop_end_valid", valid, {31'd0, model_q.size() > 0});
    endtask

    task automatic clear_ovf();
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr   = 1'b0;
        model_ovf = 1'b0;
        check("ovf_clr", overflow, 0);
    endtask

    initial begin
        logic [10:0] f;
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rd_en    = 1'b0;
        ovf_clr  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_err", frame_err, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single good frame, then one pop empties the FIFO.
        send_frame(8'h1C, 0, 1'b0);
        pop_burst(1);

        // Parity error is flagged and dropped, next good frame still lands.
        send_frame(8'h1C, 2, 1'b0);
        send_frame(8'hF0, 0, 1'b0);
        pop_burst(1);

        // Nine frames into an eight-deep FIFO; the ninth is dropped.
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1'b0);
        check("ovf_after9", overflow, 1);
        pop_burst(8);
        clear_ovf();

        // Full FIFO with a pop coinciding with the ninth stop bit.
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 0, 1'b0);
        send_frame(8'h09, 0, 1'b1);
        check("ovf_full_pop", overflow, 0);
        pop_burst(8);

        // Stalled partial frame is abandoned silently.
        begin
            int err_before;
            err_before = err_hi;
            f = make_frame(8'h33, 0);
            for (int i = 0; i < 5; i++) ps2_bit(f[i]);
            ps2_data = 1'b1;
            repeat (TIMEOUT + 10) @(negedge clk);
            check("timeout_cnt", dut.cnt, 0);
            check("timeout_no_err", err_hi, err_before);
        end
        send_frame(8'h5A, 0, 1'b0);
        pop_burst(1);

        // Reset mid-frame with buffered data discards everything.
        send_frame(8'h11, 0, 1'b0);
        send_frame(8'h22, 0, 1'b0);
        send_frame(8'h33, 0, 1'b0);
        f = make_frame(8'h44, 0);
        for (int i = 0; i < 6; i++) ps2_bit(f[i]);
        @(negedge clk);
        rst = 1'b1;
        model_q.delete();
        model_ovf = 1'b0;
        ps2_data  = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_err", frame_err, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h29, 0, 1'b0);
        pop_burst(2);

        // Random traffic against the queue model.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            int         kind;
            bit         popf;
            b    = 8'($urandom_range(0, 255));
            kind = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            popf = ($urandom_range(0, 3) == 0);
            send_frame(b, kind, popf);
            if ($urandom_range(0, 2) == 0) pop_burst(int'($urandom_range(1, 3)));
            if ($urandom_range(0, 5) == 0) clear_ovf();
        end
        pop_burst(DEPTH + 1);

        check("err_pulse_total", err_hi, bad_sent);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

Receives PS/2 keyboard frames on the raw `ps2_clk`/`ps2_data` pins, validates each frame and buffers the 8-bit scancodes in a small show-ahead FIFO. It sits directly upstream of the MuxKey-based decode stage: `data` is the key presented to the scancode→ASCII/seven-segment lookup, and `valid`/`rd_en` pace that consumer. Errors are flagged, never forwarded.

## Interface
- `DEPTH_LOG2`, default 3: FIFO depth = 2^DEPTH_LOG2 entries (8).
- `TIMEOUT`, default 2000: idle `clk` cycles mid-frame before the bit counter resynchronises. The timeout counter width is clog2(TIMEOUT+1).

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data, asynchronous to `clk`.
- `rd_en`  in  1  pop the head entry; ignored when `valid`=0.
- `ovf_clr`  in  1  clears `overflow`.
- `data`  out  8  FIFO head scancode (show-ahead); undefined when `valid`=0.
- `valid`  out  1  FIFO non-empty.
- `overflow`  out  1  sticky: a good frame was dropped because the FIFO was full.
- `frame_err`  out  1  one-cycle pulse: a frame failed its start, parity or stop check.

## Operation
- Synchroniser: `ps2_clk` → s1 → s2 → s3 (three flops); `ps2_data` → d1 → d2 (two flops).
- Edge detection: `fall` = s3 & ~s2.
- Receiver: 4-bit `cnt` (0..10) and 10-bit `buf`.
  - On `fall` with `cnt`<10: buf[cnt] ← d2, cnt ← cnt+1.
  - On `fall` with `cnt`==10: d2 is the stop bit; evaluate the frame and set cnt ← 0.
- Frame good iff buf[0]==0 (start), d2==1 (stop) and ^buf[9:1]==1 (odd parity over data plus parity). Scancode = buf[8:1].
- Good frame with push allowed: write the scancode at the write pointer and increment it.
- Good frame with FIFO full and no pop: drop it and set `overflow`. Already-stored entries are not disturbed.
- Bad frame: `frame_err`=1 for exactly that cycle and nothing is pushed.
- Timeout: the idle counter clears on every `fall` and on `cnt`==0. When `cnt`≠0 and it reaches TIMEOUT: cnt ← 0, idle counter ← 0, no `frame_err`.
- FIFO pointers: `wp` and `rp` are DEPTH_LOG2+1 bits.
  - empty: wp==rp.
  - full: MSBs differ and the low bits are equal.
  - `data` = mem[rp low bits], read combinationally.
- Pop fires when `rd_en` & `valid`: rp ← rp+1.
- Push is allowed when !full or pop fires in the same cycle. Full plus simultaneous pop and push: both happen, and occupancy stays at 2^DEPTH_LOG2.
- `overflow` priority: a set in the same cycle as `ovf_clr` wins.

## Timing
- Reset values (asynchronous): s1..s3=1, d1/d2=1, cnt=0, buf=0, idle=0, wp=rp=0, `valid`=0, `overflow`=0, `frame_err`=0, `data`=mem[0] (contents undefined, not reset).
- Latency: a pin falling edge produces `fall` in the 3rd `clk` cycle after it is sampled by s1. The push commits at the end of that `fall` cycle, and `valid`/`data` update the following cycle.
- Pop takes effect at the clock edge. The next entry appears on `data` in the following cycle. Back-to-back pops are allowed every cycle.
- `frame_err` is high for one cycle, coincident with the stop-bit `fall` cycle.
- `rst` asserted mid-frame or with the FIFO non-empty discards all partial and buffered data. The first `fall` after release is treated as a start bit.
- PS/2 clock is at most 16.7 kHz and `clk` is ≥1 MHz, so one `fall` occurs per PS/2 bit. No glitch filtering beyond synchronisation is required.

## Test plan
- Single frame 0x1C (pin bits, in order: 0, 0,0,1,1,1,0,0,0, parity 0, stop 1) → `valid` rises 1 cycle after the stop `fall`, `data`=0x1C. One `rd_en` → `valid`=0.
- 0x1C sent with parity 1 → one-cycle `frame_err` at the stop `fall`, `valid` stays 0. A following good 0xF0 frame (parity 1) is received correctly.
- Nine good frames 0x01..0x09 with no pops → `overflow`=1 after the 9th. Eight pops return 0x01..0x08 in order, then `valid`=0. `ovf_clr` → `overflow`=0.
- FIFO full, `rd_en` held during the 9th frame's stop `fall` → 0x09 accepted, no `overflow`. Subsequent pops return 0x02..0x09.
- Five bits of a frame, then pins idle for TIMEOUT+10 cycles → no `frame_err`, `cnt` returns to 0. A following good 0x5A frame yields `data`=0x5A.
- `rst` pulsed after bit 6 of a frame with 3 entries buffered → all outputs at reset values. A subsequent good 0x29 frame is the only entry.
